// File: rtl/seq_control_unit.sv
// Micro-sequencer: fetches 32-bit words, sequences LOAD_A / LOAD_B / EXEC bus micro-ops, keeps pc.
// Latency: 4 cycles per legal instruction (FETCH accept + 3 micro-op cycles); strobes are Moore outputs.
// Backpressure: instr_ready is high only in FETCH; pc and state hold while instr_valid is low.
module seq_control_unit #(
  parameter int          PC_WIDTH = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [4:0]          alu_function_sel,
  output logic                alu_store_1,
  output logic                alu_store_2,
  output logic                alu_broadcast,
  output logic [4:0]          register_index,
  output logic                register_read_enable,
  output logic                register_write_enable,
  output logic [31:0]         imm,
  output logic                imm_EN,
  output logic                retired,
  output logic                illegal_instr,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                illegal_q, illegal_d;

  logic [4:0] ir_func, ir_rd, ir_rs1, ir_rs2, in_func;
  logic       ir_use_imm;
  logic       accept;

  assign ir_func    = ir_q[31:27];
  assign ir_rd      = ir_q[26:22];
  assign ir_rs1     = ir_q[21:17];
  assign ir_rs2     = ir_q[16:12];
  assign ir_use_imm = ir_q[11];
  assign in_func    = instr[31:27];

  assign accept = instr_ready && instr_valid;
  assign pc     = pc_q;

  // Next-state: accept in FETCH, then walk the fixed micro-op sequence; HALT is terminal.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          ir_d = instr;
          pc_d = pc_q + 1'b1;
          if (in_func <= 5'd13) begin
            state_d = S_LOAD_A;
          end else if (in_func == 5'd31) begin
            state_d = S_HALT;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // State, pc, instruction register and the delayed illegal pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_WIDTH'(RESET_PC);
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobe decode from state and ir; forced quiet while reset is asserted so a
  // half-finished instruction cannot touch the datapath in the reset cycle.
  always_comb begin
    instr_ready           = 1'b0;
    alu_function_sel      = 5'd0;
    alu_store_1           = 1'b0;
    alu_store_2           = 1'b0;
    alu_broadcast         = 1'b0;
    register_index        = 5'd0;
    register_read_enable  = 1'b0;
    register_write_enable = 1'b0;
    imm                   = 32'd0;
    imm_EN                = 1'b0;
    retired               = 1'b0;
    illegal_instr         = 1'b0;
    halted                = 1'b0;
    if (!reset) begin
      illegal_instr = illegal_q;
      case (state_q)
        S_FETCH: instr_ready = 1'b1;
        S_LOAD_A: begin
          register_index       = ir_rs1;
          register_read_enable = 1'b1;
          alu_store_1          = 1'b1;
        end
        S_LOAD_B: begin
          alu_store_2 = 1'b1;
          if (ir_use_imm) begin
            imm_EN = 1'b1;
            imm    = {{21{ir_q[10]}}, ir_q[10:0]};
          end else begin
            register_index       = ir_rs2;
            register_read_enable = 1'b1;
          end
        end
        S_EXEC: begin
          alu_function_sel      = ir_func;
          alu_broadcast         = 1'b1;
          register_index        = ir_rd;
          register_write_enable = 1'b1;
          retired               = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
